// File: rtl/mem_pkg.sv
// Shared SRAM-side definitions used by the memory port arbiter and the serial SRAM controller.
package mem_pkg;

    localparam int ADDRESS_LEN = 17;
    localparam int WORD_SIZE   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (A) and data (B) requesters.
// MEM_ARB_ROUND_ROBIN_EN: alternate on ties using last_grant; otherwise B always beats A.
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_grant,
    output logic valid,
    output logic grant
);

    assign valid = a_req | b_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = GRANT_A;
        if (a_req && b_req) begin
            grant = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (b_req) begin
            grant = GRANT_B;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = b_req ? GRANT_B : GRANT_A;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter owning the serial SRAM controller request interface.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see mem_arb_pick).
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_LEN,
    parameter int WORD_W = WORD_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [WORD_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WORD_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [WORD_W-1:0] b_rdata,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_write_value,
    output logic              mem_write_enable,
    input  logic              mem_request_complete,
    input  logic [WORD_W-1:0] mem_read_value
);

    state_t state, state_d;
    grant_t grant_q;
    logic   pick_valid;
    logic   pick_grant;
    logic   last_grant;
    logic   do_grant;
    logic   do_complete;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_t last_grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_A;
        end else if (ena && do_grant) begin
            last_grant_q <= grant_t'(pick_grant);
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = GRANT_A;
`endif

    mem_arb_pick u_pick (
        .a_req      (a_req),
        .b_req      (b_req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    always_comb begin
        state_d     = state;
        do_grant    = 1'b0;
        do_complete = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    do_grant = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_request_complete) begin
                    do_complete = 1'b1;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                // Hold off until the controller drops complete so its bit counter re-arms.
                if (!mem_request_complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q          <= GRANT_A;
            mem_request      <= 1'b0;
            mem_address      <= '0;
            mem_write_value  <= '0;
            mem_write_enable <= 1'b0;
            a_ack            <= 1'b0;
            b_ack            <= 1'b0;
            a_rdata          <= '0;
            b_rdata          <= '0;
        end else if (!ena) begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            if (do_grant) begin
                grant_q     <= grant_t'(pick_grant);
                mem_request <= 1'b1;
                if (pick_grant == GRANT_B) begin
                    mem_address      <= b_addr;
                    mem_write_value  <= b_wdata;
                    mem_write_enable <= b_we;
                end else begin
                    mem_address      <= a_addr;
                    mem_write_value  <= '0;
                    mem_write_enable <= 1'b0;
                end
            end
            if (do_complete) begin
                mem_request <= 1'b0;
                if (grant_q == GRANT_B) begin
                    b_ack <= 1'b1;
                    if (!mem_write_enable) begin
                        b_rdata <= mem_read_value;
                    end
                end else begin
                    a_ack   <= 1'b1;
                    a_rdata <= mem_read_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural SRAM controller model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int AW = 17;
    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          rst, ena;
    logic          a_req, a_ack, b_req, b_we, b_ack;
    logic [AW-1:0] a_addr, b_addr, mem_address;
    logic [WW-1:0] a_rdata, b_rdata, b_wdata, mem_write_value, mem_read_value;
    logic          mem_request, mem_write_enable, mem_request_complete;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ena                  (ena),
        .a_req                (a_req),
        .a_addr               (a_addr),
        .a_ack                (a_ack),
        .a_rdata              (a_rdata),
        .b_req                (b_req),
        .b_we                 (b_we),
        .b_addr               (b_addr),
        .b_wdata              (b_wdata),
        .b_ack                (b_ack),
        .b_rdata              (b_rdata),
        .mem_request          (mem_request),
        .mem_address          (mem_address),
        .mem_write_value      (mem_write_value),
        .mem_write_enable     (mem_write_enable),
        .mem_request_complete (mem_request_complete),
        .mem_read_value       (mem_read_value)
    );

    // Controller model: complete after lat cycles of request, held until request drops.
    logic          cmpl, spur;
    int unsigned   lat, cnt;
    logic [WW-1:0] model_rdata;

    assign mem_request_complete = cmpl | spur;
    assign mem_read_value       = model_rdata ^ mem_address[15:0];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cmpl <= 1'b0;
            cnt  <= 0;
        end else if (mem_request && !cmpl) begin
            if (cnt + 1 >= lat) cmpl <= 1'b1;
            cnt <= cnt + 1;
        end else if (!mem_request) begin
            cmpl <= 1'b0;
            cnt  <= 0;
        end
    end

    typedef struct {
        logic          port_b;
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wval;
        logic [WW-1:0] rdata;
    } exp_t;

    typedef struct {
        logic          port_b;
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        logic [WW-1:0] rdata;
        int            lat;
    } vec_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            ack_total = 0;
    logic [WW-1:0] mdl_a = '0;
    logic [WW-1:0] mdl_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic port_b, input logic we, input logic [AW-1:0] addr,
                        input logic [WW-1:0] wdata, input logic [WW-1:0] rd);
        exp_t e;
        e.port_b = port_b;
        e.addr   = addr;
        e.we     = port_b ? we : 1'b0;
        e.wval   = port_b ? wdata : '0;
        if (port_b && we) begin
            e.rdata = mdl_b;
        end else if (port_b) begin
            e.rdata = rd;
            mdl_b   = rd;
        end else begin
            e.rdata = rd;
            mdl_a   = rd;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: checks issued commands against the scoreboard head and pops on ack.
    logic prev_req = 1'b0, prev_a = 1'b0, prev_b = 1'b0;
    int   low_cnt  = 2;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
            prev_a   = 1'b0;
            prev_b   = 1'b0;
            low_cnt  = 2;
        end else begin
            if (mem_request) begin
                if (!prev_req) chk("req_gap", low_cnt >= 2, 1'b1);
                chk("req_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("mem_address", mem_address, exp_q[0].addr);
                    chk("mem_write_enable", mem_write_enable, exp_q[0].we);
                    chk("mem_write_value", mem_write_value, exp_q[0].wval);
                end
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            chk("dual_ack", a_ack & b_ack, 1'b0);
            if (a_ack) begin
                ack_total++;
                chk("a_ack_width", prev_a, 1'b0);
                chk("a_ack_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("a_ack_port", exp_q[0].port_b, 1'b0);
                    chk("a_rdata", a_rdata, exp_q[0].rdata);
                    void'(exp_q.pop_front());
                end
            end
            if (b_ack) begin
                ack_total++;
                chk("b_ack_width", prev_b, 1'b0);
                chk("b_ack_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("b_ack_port", exp_q[0].port_b, 1'b1);
                    chk("b_rdata", b_rdata, exp_q[0].rdata);
                    void'(exp_q.pop_front());
                end
            end
            prev_req = mem_request;
            prev_a   = a_ack;
            prev_b   = b_ack;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input logic port_b, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (port_b ? b_ack : a_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk(port_b ? "b_ack_timeout" : "a_ack_timeout", ok, 1'b1);
    endtask

    task automatic drive(input logic port_b, input logic we, input logic [AW-1:0] addr,
                         input logic [WW-1:0] wdata);
        if (port_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_addr = addr;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   n, acks_before;

        tbl[0] = '{1'b0, 1'b0, 17'h00123, 16'h0000, 16'hBEEF, 48};
        tbl[1] = '{1'b1, 1'b1, 17'h1FFFF, 16'hA5A5, 16'h0000, 3};
        tbl[2] = '{1'b1, 1'b0, 17'h00000, 16'h7E7E, 16'h1234, 1};
        tbl[3] = '{1'b0, 1'b0, 17'h1FFFF, 16'h0000, 16'hFFFF, 2};
        tbl[4] = '{1'b1, 1'b1, 17'h0AAAA, 16'h5555, 16'h0000, 4};
        tbl[5] = '{1'b1, 1'b0, 17'h15555, 16'h0000, 16'h8001, 1};

        rst = 1'b1; ena = 1'b1; spur = 1'b0; lat = 4; model_rdata = '0;
        a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_request", mem_request, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_mem_write_value", mem_write_value, '0);
        chk("rst_mem_write_enable", mem_write_enable, 1'b0);
        chk("rst_a_ack", a_ack, 1'b0);
        chk("rst_b_ack", b_ack, 1'b0);
        chk("rst_a_rdata", a_rdata, '0);
        chk("rst_b_rdata", b_rdata, '0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lat         = tbl[i].lat;
            model_rdata = tbl[i].rdata ^ tbl[i].addr[15:0];
            b_we        = 1'b1;
            b_wdata     = 16'hDEAD;
            push(tbl[i].port_b, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
            drive(tbl[i].port_b, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            @(posedge clk);
            #1 chk("grant_latency", mem_request, 1'b1);
            wait_ack(tbl[i].port_b, 200);
            if (tbl[i].port_b) b_req = 1'b0; else a_req = 1'b0;
            idle(3);
        end

        // Spurious complete while idle must be ignored.
        acks_before = ack_total;
        spur = 1'b1;
        idle(1);
        spur = 1'b0;
        idle(2);
        chk("spurious_no_req", mem_request, 1'b0);
        chk("spurious_no_ack", ack_total, acks_before);

        // Simultaneous requests, then B re-raises while A is still waiting.
        model_rdata = 16'h1111;
        lat = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(1'b1, 1'b0, 17'h00B01, '0, 16'h1111 ^ 16'h0B01);
        push(1'b0, 1'b0, 17'h00A01, '0, 16'h1111 ^ 16'h0A01);
        push(1'b1, 1'b0, 17'h00B02, '0, 16'h1111 ^ 16'h0B02);
`else
        push(1'b1, 1'b0, 17'h00B01, '0, 16'h1111 ^ 16'h0B01);
        push(1'b1, 1'b0, 17'h00B02, '0, 16'h1111 ^ 16'h0B02);
        push(1'b0, 1'b0, 17'h00A01, '0, 16'h1111 ^ 16'h0A01);
`endif
        drive(1'b0, 1'b0, 17'h00A01, '0);
        drive(1'b1, 1'b0, 17'h00B01, 16'h0000);
        wait_ack(1'b1, 100);
        b_req = 1'b0;
        idle(1);
        drive(1'b1, 1'b0, 17'h00B02, 16'h0000);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        wait_ack(1'b0, 100);
        a_req = 1'b0;
        wait_ack(1'b1, 100);
        b_req = 1'b0;
`else
        wait_ack(1'b1, 100);
        b_req = 1'b0;
        wait_ack(1'b0, 100);
        a_req = 1'b0;
`endif
        idle(3);

        // Stuck request: second transaction only after RELEASE sees complete low.
        lat = 2;
        model_rdata = 16'hC0DE ^ 16'h0456;
        push(1'b0, 1'b0, 17'h00456, '0, 16'hC0DE);
        push(1'b0, 1'b0, 17'h00456, '0, 16'h0BAD);
        drive(1'b0, 1'b0, 17'h00456, '0);
        wait_ack(1'b0, 100);
        model_rdata = 16'h0BAD ^ 16'h0456;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_request && n < 20);
        chk("stuck_regrant_delay", n, 3);
        wait_ack(1'b0, 100);
        a_req = 1'b0;
        idle(3);

        // Reset in the middle of ISSUE abandons the transaction; held b_req is re-granted.
        lat = 40;
        model_rdata = 16'h7777 ^ 16'h0C0C;
        push(1'b1, 1'b0, 17'h00C0C, 16'h0000, 16'h7777);
        drive(1'b1, 1'b0, 17'h00C0C, 16'h0000);
        n = 0;
        while (!mem_request && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk("rst_test_granted", mem_request, 1'b1);
        acks_before = ack_total;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_request", mem_request, 1'b0);
        chk("async_rst_b_ack", b_ack, 1'b0);
        lat = 3;
        idle(3);
        rst = 1'b0;
        chk("rst_no_ack", ack_total, acks_before);
        @(posedge clk);
        #1 chk("rst_regrant", mem_request, 1'b1);
        wait_ack(1'b1, 100);
        b_req = 1'b0;
        idle(3);

        // ena low across the complete: ack is deferred until ena returns.
        lat = 6;
        model_rdata = 16'h3C3C ^ 16'h0D0D;
        push(1'b1, 1'b0, 17'h00D0D, 16'h0000, 16'h3C3C);
        drive(1'b1, 1'b0, 17'h00D0D, 16'h0000);
        @(posedge clk);
        #1 chk("ena_test_granted", mem_request, 1'b1);
        idle(2);
        ena = 1'b0;
        acks_before = ack_total;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ena_low_no_ack", a_ack | b_ack, 1'b0);
            chk("ena_low_req_held", mem_request, 1'b1);
        end
        chk("ena_low_complete_seen", mem_request_complete, 1'b1);
        ena = 1'b1;
        wait_ack(1'b1, 10);
        b_req = 1'b0;
        idle(4);
        chk("ena_single_ack", ack_total - acks_before, 1);

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
